// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: change codes, coin values, dispenser states.
package vm_pkg;

  localparam logic [1:0] R0  = 2'b00;
  localparam logic [1:0] R5  = 2'b01;
  localparam logic [1:0] R10 = 2'b10;
  localparam logic [1:0] R15 = 2'b11;

  localparam int unsigned COIN5  = 5;
  localparam int unsigned COIN10 = 10;

  typedef enum logic [3:0] {
    IDLE, PROD, PLAN, EJ10, W10, EJ5, W5, DONE, FAULT
  } state_t;

  // Change owed, expressed in 5 tk units.
  function automatic logic [2:0] change_units(input logic [1:0] code);
    int unsigned tk;
    tk = 0;
    case (code)
      R0:  tk = 0;
      R5:  tk = COIN5;
      R10: tk = COIN10;
      R15: tk = COIN10 + COIN5;
      default: tk = 0;
    endcase
    return 3'(tk / COIN5);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that stops at zero; shared by solenoid pulses and sensor waits.
module pulse_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - W'(1);
  end

endmodule

// File: rtl/change_dispenser.sv
// Fires the product solenoid, then pays change from the 10 tk and 5 tk hoppers with
// drop-sensor confirmation, inventory tracking and a sticky jam fault.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned INIT5     = 20,
  parameter int unsigned INIT10    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             txn_valid,
  input  logic             purchase,
  input  logic [1:0]       cash_return,
  input  logic             coin_sense,
  input  logic             refill5,
  input  logic             refill10,
  output logic             ready,
  output logic             product_eject,
  output logic             eject5,
  output logic             eject10,
  output logic [CNT_W-1:0] count5,
  output logic [CNT_W-1:0] count10,
  output logic             done,
  output logic             short_change,
  output logic             overrun,
  output logic             fault
);

  localparam int unsigned TMAX = (TIMEOUT > PULSE_CYC) ? TIMEOUT : PULSE_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] WAIT_LD  = TW'(TIMEOUT - 1);

  state_t        state;
  logic [2:0]    units;
  logic [2:0]    n10_left;
  logic [2:0]    n5_left;
  logic [2:0]    plan_n10;
  logic [2:0]    plan_n5;
  logic [2:0]    plan_rem;
  logic          plan_short;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic [TW-1:0] tmr_count;
  logic          dec5;
  logic          dec10;

  pulse_timer #(.W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .count (tmr_count)
  );

  assign dec5  = (state == W5)  && coin_sense;
  assign dec10 = (state == W10) && coin_sense;

  // Coin plan: prefer 10 tk coins, top up with 5 tk coins from whatever is left.
  always_comb begin
    plan_n10 = ((units >> 1) != 3'd0 && count10 != '0) ? 3'd1 : 3'd0;
    plan_rem = units - (plan_n10 << 1);
    if (count5 < CNT_W'(plan_rem))
      plan_n5 = 3'(count5);
    else
      plan_n5 = plan_rem;
    plan_short = plan_n5 < plan_rem;
  end

  // Timer reloads on every entry into a pulse or a sensor wait.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE: if (txn_valid && purchase) begin
        tmr_load  = 1'b1;
        tmr_value = PULSE_LD;
      end
      PLAN: if (plan_n10 != 3'd0 || plan_n5 != 3'd0) begin
        tmr_load  = 1'b1;
        tmr_value = PULSE_LD;
      end
      EJ10, EJ5: if (tmr_count == '0) begin
        tmr_load  = 1'b1;
        tmr_value = WAIT_LD;
      end
      W10, W5: if (coin_sense) begin
        tmr_load  = 1'b1;
        tmr_value = PULSE_LD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ready         <= 1'b1;
      product_eject <= 1'b0;
      eject5        <= 1'b0;
      eject10       <= 1'b0;
      done          <= 1'b0;
      short_change  <= 1'b0;
      overrun       <= 1'b0;
      fault         <= 1'b0;
      units         <= 3'd0;
      n10_left      <= 3'd0;
      n5_left       <= 3'd0;
    end else begin
      done    <= 1'b0;
      overrun <= txn_valid && (state != IDLE);
      case (state)
        IDLE: if (txn_valid) begin
          units        <= change_units(cash_return);
          short_change <= 1'b0;
          ready        <= 1'b0;
          if (purchase) begin
            state         <= PROD;
            product_eject <= 1'b1;
          end else begin
            state <= PLAN;
          end
        end
        PROD: if (tmr_count == '0) begin
          product_eject <= 1'b0;
          state         <= PLAN;
        end
        PLAN: begin
          n10_left <= plan_n10;
          n5_left  <= plan_n5;
          if (plan_short) short_change <= 1'b1;
          if (plan_n10 != 3'd0) begin
            state   <= EJ10;
            eject10 <= 1'b1;
          end else if (plan_n5 != 3'd0) begin
            state  <= EJ5;
            eject5 <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        EJ10: if (tmr_count == '0) begin
          eject10 <= 1'b0;
          state   <= W10;
        end
        W10: if (coin_sense) begin
          n10_left <= n10_left - 3'd1;
          if (n10_left > 3'd1) begin
            state   <= EJ10;
            eject10 <= 1'b1;
          end else if (n5_left != 3'd0) begin
            state  <= EJ5;
            eject5 <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end else if (tmr_count == '0) begin
          state <= FAULT;
          fault <= 1'b1;
        end
        EJ5: if (tmr_count == '0) begin
          eject5 <= 1'b0;
          state  <= W5;
        end
        W5: if (coin_sense) begin
          n5_left <= n5_left - 3'd1;
          if (n5_left > 3'd1) begin
            state  <= EJ5;
            eject5 <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end else if (tmr_count == '0) begin
          state <= FAULT;
          fault <= 1'b1;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        FAULT: fault <= 1'b1;
        default: state <= FAULT;
      endcase
    end
  end

  // Hopper inventory: a refill and a confirmed drop in the same cycle cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      count5  <= CNT_W'(INIT5);
      count10 <= CNT_W'(INIT10);
    end else begin
      if (refill5 && !dec5) begin
        if (count5 != '1) count5 <= count5 + CNT_W'(1);
      end else if (dec5 && !refill5 && count5 != '0) begin
        count5 <= count5 - CNT_W'(1);
      end
      if (refill10 && !dec10) begin
        if (count10 != '1) count10 <= count10 + CNT_W'(1);
      end else if (dec10 && !refill10 && count10 != '0) begin
        count10 <= count10 - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table of whole transactions plus corner sequences.
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       txn_valid = 1'b0;
  logic       purchase = 1'b0;
  logic [1:0] cash_return = 2'b00;
  logic       coin_sense = 1'b0;
  logic       refill5 = 1'b0;
  logic       refill10 = 1'b0;
  logic       ready, product_eject, eject5, eject10, done, short_change, overrun, fault;
  logic [7:0] count5, count10;

  int n_cmp = 0;
  int n_bad = 0;

  logic auto_sense = 1'b1;
  logic refill_with_sense = 1'b0;
  int   refill5_pulses = 0;
  int   refill10_pulses = 0;
  logic prev_e10 = 1'b0;
  logic prev_e5 = 1'b0;

  change_dispenser dut (
    .clock         (clock),
    .reset         (reset),
    .txn_valid     (txn_valid),
    .purchase      (purchase),
    .cash_return   (cash_return),
    .coin_sense    (coin_sense),
    .refill5       (refill5),
    .refill10      (refill10),
    .ready         (ready),
    .product_eject (product_eject),
    .eject5        (eject5),
    .eject10       (eject10),
    .count5        (count5),
    .count10       (count10),
    .done          (done),
    .short_change  (short_change),
    .overrun       (overrun),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  // Hopper model: one sensor pulse the cycle after each coin solenoid releases.
  always @(negedge clock) begin
    coin_sense = 1'b0;
    refill10   = 1'b0;
    refill5    = 1'b0;
    if (refill5_pulses > 0) begin
      refill5 = 1'b1;
      refill5_pulses = refill5_pulses - 1;
    end
    if (refill10_pulses > 0) begin
      refill10 = 1'b1;
      refill10_pulses = refill10_pulses - 1;
    end
    if (auto_sense && ((prev_e10 && !eject10) || (prev_e5 && !eject5))) begin
      coin_sense = 1'b1;
      if (refill_with_sense && prev_e10 && !eject10) refill10 = 1'b1;
    end
    prev_e10 = eject10;
    prev_e5  = eject5;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue one transaction and follow it until done (or the cycle budget expires).
  task automatic run_txn(input logic p, input logic [1:0] code, input int inject_at,
                         output int lat, output int prod, output int e10, output int e5,
                         output int ovr, output int ready_low);
    int   w;
    logic pe10, pe5;
    w = 0;
    while (!ready && w < 500) begin
      @(negedge clock);
      w++;
    end
    check("ready_before_txn", int'(ready), 1);
    purchase    = p;
    cash_return = code;
    txn_valid   = 1'b1;
    @(negedge clock);
    txn_valid = 1'b0;
    lat = 0; prod = 0; e10 = 0; e5 = 0; ovr = 0; ready_low = 0;
    pe10 = 1'b0; pe5 = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (k == 1) ready_low = int'(!ready);
      if (product_eject) prod++;
      if (eject10 && !pe10) e10++;
      if (eject5 && !pe5) e5++;
      pe10 = eject10;
      pe5  = eject5;
      if (overrun) ovr++;
      txn_valid   = (k == inject_at);
      purchase    = 1'b0;
      cash_return = 2'b11;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    txn_valid = 1'b0;
  endtask

  typedef struct {
    logic       p;
    logic [1:0] code;
    int         lat;
    int         prod;
    int         e10;
    int         e5;
    int         c5;
    int         c10;
    int         sc;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int lat, prod, e10, e5, ovr, rl, w;

    // Transaction chain from counts 20/10; latency = prod + 1 + coins*(PULSE+1) + 1.
    vecs[0]  = '{1'b1, 2'b11, 16, 4, 1, 1, 19, 9, 0};
    vecs[1]  = '{1'b0, 2'b00,  2, 0, 0, 0, 19, 9, 0};
    vecs[2]  = '{1'b0, 2'b01,  7, 0, 0, 1, 18, 9, 0};
    vecs[3]  = '{1'b1, 2'b10, 11, 4, 1, 0, 18, 8, 0};
    for (int i = 0; i < 8; i++) vecs[4+i] = '{1'b0, 2'b10, 7, 0, 1, 0, 18, 7 - i, 0};
    vecs[12] = '{1'b0, 2'b10, 12, 0, 0, 2, 16, 0, 0};
    vecs[13] = '{1'b0, 2'b11, 17, 0, 0, 3, 13, 0, 0};
    vecs[14] = '{1'b0, 2'b11, 17, 0, 0, 3, 10, 0, 0};
    vecs[15] = '{1'b0, 2'b11, 17, 0, 0, 3,  7, 0, 0};
    vecs[16] = '{1'b0, 2'b11, 17, 0, 0, 3,  4, 0, 0};
    vecs[17] = '{1'b0, 2'b11, 17, 0, 0, 3,  1, 0, 0};
    vecs[18] = '{1'b0, 2'b11,  7, 0, 0, 1,  0, 0, 1};
    vecs[19] = '{1'b0, 2'b01,  2, 0, 0, 0,  0, 0, 1};
    vecs[20] = '{1'b1, 2'b00,  6, 4, 0, 0,  0, 0, 0};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset.ready", int'(ready), 1);
    check("reset.count5", int'(count5), 20);
    check("reset.count10", int'(count10), 10);
    check("reset.others", int'({product_eject, eject5, eject10, done, short_change, overrun, fault}), 0);

    for (int i = 0; i < 21; i++) begin
      run_txn(vecs[i].p, vecs[i].code, 0, lat, prod, e10, e5, ovr, rl);
      check($sformatf("v%0d.latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d.prod_cycles", i), prod, vecs[i].prod);
      check($sformatf("v%0d.eject10", i), e10, vecs[i].e10);
      check($sformatf("v%0d.eject5", i), e5, vecs[i].e5);
      check($sformatf("v%0d.count5", i), int'(count5), vecs[i].c5);
      check($sformatf("v%0d.count10", i), int'(count10), vecs[i].c10);
      check($sformatf("v%0d.short_change", i), int'(short_change), vecs[i].sc);
      check($sformatf("v%0d.ready_drop", i), rl, 1);
      check($sformatf("v%0d.overrun", i), ovr, 0);
      @(negedge clock);
      check($sformatf("v%0d.ready_done_after", i), int'({ready, done}), 2);
    end

    // Strobe during the product pulse is dropped and flagged.
    do_reset();
    run_txn(1'b1, 2'b10, 2, lat, prod, e10, e5, ovr, rl);
    check("ovr.overrun_pulses", ovr, 1);
    check("ovr.latency", lat, 11);
    check("ovr.prod_cycles", prod, 4);
    check("ovr.eject10", e10, 1);
    check("ovr.eject5", e5, 0);
    check("ovr.count10", int'(count10), 9);
    check("ovr.count5", int'(count5), 20);
    @(negedge clock);

    // Refill coincident with a 10 tk drop nets to zero.
    refill_with_sense = 1'b1;
    run_txn(1'b0, 2'b10, 0, lat, prod, e10, e5, ovr, rl);
    refill_with_sense = 1'b0;
    check("coinc.eject10", e10, 1);
    check("coinc.count10", int'(count10), 9);
    @(negedge clock);

    refill10_pulses = 3;
    repeat (6) @(negedge clock);
    check("refill10.count10", int'(count10), 12);

    refill5_pulses = 240;
    repeat (250) @(negedge clock);
    check("refill5.saturate", int'(count5), 255);

    // Withheld sensor: fault after TIMEOUT wait cycles, then stuck until reset.
    auto_sense = 1'b0;
    purchase = 1'b0;
    cash_return = 2'b01;
    txn_valid = 1'b1;
    @(negedge clock);
    txn_valid = 1'b0;
    w = 0;
    while (!eject5 && w < 50) begin @(negedge clock); w++; end
    check("jam.eject5_seen", int'(eject5), 1);
    w = 0;
    while (eject5 && w < 50) begin @(negedge clock); w++; end
    check("jam.eject5_cycles", w, 4);
    w = 0;
    while (!fault && w < 1000) begin @(negedge clock); w++; end
    check("jam.wait_cycles", w, 255);
    check("jam.ready", int'(ready), 0);
    check("jam.count5", int'(count5), 255);
    repeat (20) @(negedge clock);
    check("jam.sticky", int'({fault, ready, eject5, eject10, product_eject}), 16);

    auto_sense = 1'b1;
    do_reset();
    check("jam_reset.fault_ready", int'({fault, ready}), 1);
    check("jam_reset.count5", int'(count5), 20);

    // Reset in the middle of a 10 tk pulse aborts at the next edge.
    purchase = 1'b0;
    cash_return = 2'b10;
    txn_valid = 1'b1;
    @(negedge clock);
    txn_valid = 1'b0;
    w = 0;
    while (!eject10 && w < 50) begin @(negedge clock); w++; end
    check("midrst.eject10_seen", int'(eject10), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst.eject10", int'(eject10), 0);
    check("midrst.ready", int'(ready), 1);
    check("midrst.count10", int'(count10), 10);
    check("midrst.count5", int'(count5), 20);

    run_txn(1'b1, 2'b11, 0, lat, prod, e10, e5, ovr, rl);
    check("post.latency", lat, 16);
    check("post.coins", e10 * 10 + e5, 11);
    check("post.counts", int'(count5) * 256 + int'(count10), 19 * 256 + 9);
    check("post.overrun", ovr + rl, 1);
    check("post.prod_cycles", prod, 4);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
